// File: rtl/imem_rsp_pkg.sv
// Shared widths, FSM state encoding and request-entry layout for the
// instruction-memory line responder.
package imem_rsp_pkg;

    localparam int PADDR_W  = 15;
    localparam int LINE_W   = 128;
    localparam int BEAT_W   = 32;
    localparam int ID_W     = 4;
    localparam int LINE_A_W = PADDR_W - 4;   // line index, paddr[14:4]
    localparam int BEATS    = LINE_W / BEAT_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_REQ       = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_ACK  = 3'd5,
        ST_RELEASE   = 3'd6
    } rsp_state_e;

    typedef struct packed {
        logic [LINE_A_W-1:0] line;
        logic [ID_W-1:0]     id;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    // Byte address of one 32-bit beat inside a 16-byte line.
    function automatic logic [PADDR_W-1:0] beat_addr(
        input logic [LINE_A_W-1:0] line,
        input logic [1:0]          beat
    );
        return {line, beat, 2'b00};
    endfunction

endpackage

// File: rtl/line_req_fifo.sv
// Small power-of-two request FIFO. Full/empty come from a registered
// occupancy count, so a pop never frees a slot for a push in the same cycle.
module line_req_fifo
    import imem_rsp_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [WIDTH-1:0] slot_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(QDEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = slot_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) slot_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/imem_line_responder.sv
// Answers I$ line-fill reads: queues requests, fetches four 32-bit beats from
// a fixed-latency memory, assembles the 128-bit line and returns it through a
// req/grant/ack/release transmit handshake, retransmitting on ack timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for a queued request; pops head into entry regs
// READ       | four cycles of memory strobes, beat 0..3
// WAIT_DATA  | draining the memory latency pipe until beat 3 lands
// REQ        | asking for a transmit slot until granted
// SEND       | one-cycle payload strobe
// WAIT_ACK   | waiting for ack; timeout sends us back to REQ
// RELEASE    | one-cycle slot release, then IDLE
module imem_line_responder
    import imem_rsp_pkg::*;
#(
    parameter int QDEPTH      = 2,
    parameter int MEM_LAT     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [14:0]   req_paddr,
    input  logic [3:0]    req_return,
    input  logic          req_rw,
    output logic          err_rw,
    output logic          mem_rd_en,
    output logic [14:0]   mem_rd_addr,
    input  logic [31:0]   mem_rd_data,
    output logic          rsp_req,
    input  logic          rsp_grant,
    output logic          rsp_valid,
    output logic [3:0]    rsp_dest,
    output logic [14:0]   rsp_paddr,
    output logic [127:0]  rsp_data,
    input  logic          rsp_ack,
    output logic          rsp_release,
    output logic          busy
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    rsp_state_e           state_q;
    rsp_state_e           state_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_rd_data;
    req_entry_t           push_entry;
    req_entry_t           head_entry;
    req_entry_t           ent_q;

    logic [1:0]           rd_beat_q;
    logic [1:0]           cap_beat_q;
    logic [MEM_LAT-1:0]   vpipe_q;
    logic                 beat_valid;
    logic [LINE_W-1:0]    line_q;
    logic [TMR_W-1:0]     tmr_q;
    logic                 err_rw_q;
    logic                 accept;

    // The byte offset within a line never matters for a line fill.
    logic                 unused_paddr_lsb;
    assign unused_paddr_lsb = ^req_paddr[3:0];

    assign req_ready  = ~fifo_full;
    assign accept     = req_valid & ~fifo_full;
    assign fifo_push  = accept & ~req_rw;
    assign push_entry = '{line: req_paddr[14:4], id: req_return};
    assign head_entry = req_entry_t'(fifo_rd_data);

    line_req_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ENTRY_W'(push_entry)),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and handshake outputs; all strobes are pure state decodes.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        mem_rd_en   = 1'b0;
        rsp_req     = 1'b0;
        rsp_valid   = 1'b0;
        rsp_release = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                if (rd_beat_q == 2'd3) state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (beat_valid && cap_beat_q == 2'd3) state_d = ST_REQ;
            end
            ST_REQ: begin
                rsp_req = 1'b1;
                if (rsp_grant) state_d = ST_SEND;
            end
            ST_SEND: begin
                rsp_valid = 1'b1;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rsp_ack)             state_d = ST_RELEASE;
                else if (tmr_q == '0)    state_d = ST_REQ;
            end
            ST_RELEASE: begin
                rsp_release = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry capture, beat sequencing, memory latency pipe and line assembly.
    // Beats return in strobe order, so a separate capture counter tracks them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q      <= '0;
            rd_beat_q  <= '0;
            cap_beat_q <= '0;
            vpipe_q    <= '0;
            line_q     <= '0;
        end else begin
            if (fifo_pop) ent_q <= head_entry;
            if (mem_rd_en) rd_beat_q <= rd_beat_q + 2'd1;
            vpipe_q[0] <= mem_rd_en;
            for (int i = 1; i < MEM_LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
            if (beat_valid) begin
                line_q[int'(cap_beat_q)*BEAT_W +: BEAT_W] <= mem_rd_data;
                cap_beat_q <= cap_beat_q + 2'd1;
            end
        end
    end

    assign beat_valid = vpipe_q[MEM_LAT-1];

    // Ack timeout: down-counter loaded on each send, terminal count at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else if (state_q == ST_SEND) begin
            tmr_q <= TMR_W'(ACK_TIMEOUT - 1);
        end else if (state_q == ST_WAIT_ACK) begin
            if (tmr_q != '0) tmr_q <= tmr_q - TMR_W'(1);
        end else begin
            tmr_q <= '0;
        end
    end

    // Write requests are dropped and flagged one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_rw_q <= 1'b0;
        else      err_rw_q <= accept & req_rw;
    end

    assign err_rw      = err_rw_q;
    assign mem_rd_addr = mem_rd_en ? beat_addr(ent_q.line, rd_beat_q) : '0;
    assign rsp_dest    = ent_q.id;
    assign rsp_paddr   = {ent_q.line, 4'b0000};
    assign rsp_data    = line_q;
    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_imem_line_responder.sv
// Bench for imem_line_responder: directed timing cases followed by random
// traffic, all checked against a memory image and an in-order response list.
module tb_imem_line_responder;

    localparam int QDEPTH      = 2;
    localparam int MEM_LAT     = 2;
    localparam int ACK_TIMEOUT = 16;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [14:0]   req_paddr;
    logic [3:0]    req_return;
    logic          req_rw;
    logic          err_rw;
    logic          mem_rd_en;
    logic [14:0]   mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          rsp_req;
    logic          rsp_grant;
    logic          rsp_valid;
    logic [3:0]    rsp_dest;
    logic [14:0]   rsp_paddr;
    logic [127:0]  rsp_data;
    logic          rsp_ack;
    logic          rsp_release;
    logic          busy;

    imem_line_responder #(
        .QDEPTH      (QDEPTH),
        .MEM_LAT     (MEM_LAT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_paddr   (req_paddr),
        .req_return  (req_return),
        .req_rw      (req_rw),
        .err_rw      (err_rw),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .rsp_req     (rsp_req),
        .rsp_grant   (rsp_grant),
        .rsp_valid   (rsp_valid),
        .rsp_dest    (rsp_dest),
        .rsp_paddr   (rsp_paddr),
        .rsp_data    (rsp_data),
        .rsp_ack     (rsp_ack),
        .rsp_release (rsp_release),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   dest;
        logic [14:0]  paddr;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [14:0] addr;
    } mreq_t;

    logic [31:0] mem [8192];
    exp_t        exp_q [$];
    mreq_t       mq [$];
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic        rx_auto;
    logic [1:0]  tb_beat;
    logic [127:0] saved;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] line_data(input logic [10:0] line);
        return {mem[{line, 2'd3}], mem[{line, 2'd2}], mem[{line, 2'd1}], mem[{line, 2'd0}]};
    endfunction

    // Advance one clock; then play memory, check responses, drive receiver.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            mem_rd_data = mem[mq[0].addr[14:2]];
            void'(mq.pop_front());
        end else begin
            mem_rd_data = $urandom;
        end
        if (mem_rd_en) begin
            mq.push_back('{due: cyc + MEM_LAT, addr: mem_rd_addr});
            chk("mem_has_line", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0)
                chk("mem_rd_addr", mem_rd_addr, {exp_q[0].paddr[14:4], tb_beat, 2'b00});
            tb_beat++;
        end
        if (rsp_valid) begin
            chk("rsp_has_exp", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                chk("rsp_dest", rsp_dest, exp_q[0].dest);
                chk("rsp_paddr", rsp_paddr, exp_q[0].paddr);
                chk("rsp_data", rsp_data, exp_q[0].data);
            end
        end
        if (rsp_release) begin
            chk("release_has_exp", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (rx_auto) begin
            rsp_grant = ($urandom_range(0, 2) == 0);
            rsp_ack   = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic send_req(input logic [14:0] pa, input logic [3:0] id, input logic rw);
        int   g;
        logic acc;
        g = 0;
        while (!req_ready && g < 500) begin
            step();
            g++;
        end
        chk("req_ready_wait", req_ready, 1);
        acc        = req_ready;
        req_valid  = 1'b1;
        req_paddr  = pa;
        req_return = id;
        req_rw     = rw;
        if (acc && !rw)
            exp_q.push_back('{dest: id, paddr: {pa[14:4], 4'b0000}, data: line_data(pa[14:4])});
        step();
        req_valid = 1'b0;
        req_rw    = 1'b0;
        chk("err_rw", err_rw, acc & rw);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            step();
            g++;
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pending"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_err_rw"}, err_rw, 0);
        chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
        chk({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
        chk({tag, "_rsp_req"}, rsp_req, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_dest"}, rsp_dest, 0);
        chk({tag, "_rsp_paddr"}, rsp_paddr, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_release"}, rsp_release, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; tb_beat = 2'd0; rx_auto = 1'b0;
        rst = 1'b0; req_valid = 1'b0; req_paddr = '0; req_return = '0; req_rw = 1'b0;
        rsp_grant = 1'b0; rsp_ack = 1'b0; mem_rd_data = '0; saved = '0;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;

        repeat (3) step();
        chk_reset_outputs("por");
        rst = 1'b1;
        repeat (2) step();

        // Single read with exact cycle timing.
        send_req(15'h1234, 4'b0001, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("t2_mem_en", mem_rd_en, 1);
            chk("t2_mem_addr", mem_rd_addr, 15'h1230 + 15'(4 * k));
            step();
        end
        chk("t2_mem_en_c6", mem_rd_en, 0);
        step();
        chk("t2_req_c7", rsp_req, 0);
        step();
        chk("t2_req_c8", rsp_req, 1);
        rsp_grant = 1'b1;
        step();
        rsp_grant = 1'b0;
        chk("t2_valid_c9", rsp_valid, 1);
        chk("t2_dest", rsp_dest, 4'b0001);
        chk("t2_paddr", rsp_paddr, 15'h1230);
        chk("t2_data", rsp_data, line_data(11'h123));
        step();
        chk("t2_valid_c10", rsp_valid, 0);
        rsp_ack = 1'b1;
        step();
        rsp_ack = 1'b0;
        chk("t2_release_c11", rsp_release, 1);
        step();
        chk("t2_release_c12", rsp_release, 0);
        chk("t2_idle_c12", busy, 0);

        // Write request is rejected.
        send_req(15'h0040, 4'b0000, 1'b1);
        step();
        chk("t4_err_once", err_rw, 0);
        chk("t4_not_queued", busy, 0);
        chk("t4_ready", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_mem", mem_rd_en, 0);
            step();
        end

        // Spurious grant/ack in IDLE and READ, then delayed grant and ack timeout.
        rsp_grant = 1'b1;
        rsp_ack   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_idle_busy", busy, 0);
            chk("t6_idle_valid", rsp_valid, 0);
        end
        send_req(15'h2A58, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t6_read_valid", rsp_valid, 0);
            chk("t6_read_req", rsp_req, 0);
            chk("t6_read_release", rsp_release, 0);
            step();
        end
        rsp_grant = 1'b0;
        rsp_ack   = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t5_req_held", rsp_req, 1);
            chk("t5_no_valid", rsp_valid, 0);
            chk("t5_payload_held", rsp_data, line_data(11'h2A5));
            step();
        end
        chk("t5_req_c13", rsp_req, 1);
        rsp_grant = 1'b1;
        step();
        rsp_grant = 1'b0;
        chk("t5_valid_first", rsp_valid, 1);
        saved = rsp_data;
        for (int k = 0; k < ACK_TIMEOUT; k++) begin
            step();
            chk("t5_wait_req", rsp_req, 0);
            chk("t5_wait_valid", rsp_valid, 0);
        end
        step();
        chk("t5_retx_req", rsp_req, 1);
        rsp_grant = 1'b1;
        step();
        rsp_grant = 1'b0;
        chk("t5_retx_valid", rsp_valid, 1);
        chk("t5_retx_same_data", rsp_data, saved);
        chk("t5_retx_dest", rsp_dest, 4'b0000);
        chk("t5_retx_paddr", rsp_paddr, 15'h2A50);
        step();
        rsp_ack = 1'b1;
        step();
        rsp_ack = 1'b0;
        chk("t5_release", rsp_release, 1);
        step();
        chk("t5_idle", busy, 0);

        // Three back-to-back requests against a two-deep queue.
        rx_auto = 1'b1;
        send_req(15'h0100, 4'b0000, 1'b0);
        send_req(15'h0210, 4'b0001, 1'b0);
        send_req(15'h0320, 4'b0000, 1'b0);
        chk("t3_ready_full", req_ready, 0);
        drain("t3");

        // Reset while waiting for memory data.
        rx_auto   = 1'b0;
        rsp_grant = 1'b0;
        rsp_ack   = 1'b0;
        send_req(15'h7FF0, 4'b0001, 1'b0);
        repeat (5) step();
        rst = 1'b0;
        #1;
        chk_reset_outputs("t1_rst");
        exp_q.delete();
        tb_beat = 2'd0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t1_no_req", rsp_req, 0);
            chk("t1_data_clear", rsp_data, 0);
        end

        // Random traffic with a randomly behaving receiver.
        rx_auto = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) step();
            send_req(15'($urandom_range(0, 32767)), 4'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0));
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
- Memory-side responder that answers instruction-cache line-fill read requests arriving from the bus deserializer (request: 15-bit pAddr, 4-bit return id).
- Buffers requests in a small queue and reads the 16-byte line as four 32-bit beats from a fixed-latency memory port.
- Assembles the beats into a 128-bit line and returns it through a req/grant/ack/release transmit handshake toward the bus serializer, tagged with the requester's id.

Parameters:
QDEPTH, 2, request queue entries (power of 2, >=2)
MEM_LAT, 2, cycles from mem_rd_en to mem_rd_data valid (>=1, fixed)
ACK_TIMEOUT, 16, cycles to wait for rsp_ack before retransmitting

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  incoming request valid
req_ready  out  1  queue can accept (not full)
req_paddr  in  15  physical byte address; bits [3:0] ignored
req_return  in  4  requester id (even I$ 0000, odd I$ 0001)
req_rw  in  1  0=read; 1 is illegal here
err_rw  out  1  one-cycle pulse: write request rejected
mem_rd_en  out  1  memory beat read strobe
mem_rd_addr  out  15  beat byte address {line[14:4], beat[1:0], 2'b00}
mem_rd_data  in  32  beat data, valid MEM_LAT cycles after strobe
rsp_req  out  1  request transmit slot
rsp_grant  in  1  slot granted
rsp_valid  out  1  one-cycle payload strobe
rsp_dest  out  4  = latched req_return
rsp_paddr  out  15  = {line[14:4], 4'b0000}
rsp_data  out  128  assembled line
rsp_ack  in  1  receiver accepted payload
rsp_release  out  1  one-cycle slot release pulse
busy  out  1  FSM not in IDLE or queue non-empty

Behaviour:
- Reset (rst=0, async): queue emptied, FSM=IDLE, beat counter/valid pipe/timeout cleared. All outputs 0 except req_ready=1. In-flight memory data is discarded.
- Enqueue: req_valid & req_ready & ~req_rw. req_ready = ~full from registered count. A pop in the same cycle does not free a slot that cycle.
- req_valid & req_ready & req_rw: not enqueued; err_rw=1 next cycle for exactly 1 cycle.
- FSM states:
  - IDLE: non-empty -> pop head into entry regs -> READ.
  - READ: 4 cycles, mem_rd_en=1, beat=0..3 -> WAIT_DATA.
  - WAIT_DATA: valid pipe of depth MEM_LAT delays each strobe. Returning beat k writes rsp_data[32k+31:32k]; others hold. After beat 3 captured -> REQ.
  - REQ: rsp_req=1 until rsp_grant sampled high -> SEND.
  - SEND: rsp_valid=1 one cycle; dest/paddr/data stable from SEND until RELEASE ends -> WAIT_ACK.
  - WAIT_ACK: rsp_ack -> RELEASE. ACK_TIMEOUT cycles without ack -> REQ (retransmit, same payload; counter cleared).
  - RELEASE: rsp_release=1 one cycle -> IDLE.
- Latency, empty idle, MEM_LAT=2, accept at cycle 0:
  - pop cycle 1
  - mem_rd_en cycles 2-5
  - beat 3 captured end of cycle 7
  - rsp_req from cycle 8; grant in cycle 8 -> rsp_valid cycle 9
  - ack in cycle 10 -> rsp_release cycle 11 -> IDLE cycle 12
- rsp_grant and rsp_ack are ignored outside REQ and WAIT_ACK respectively.
- Queue pointers wrap modulo QDEPTH. Count saturates logic: full when count==QDEPTH.
- Only one line is in service at a time. Responses are issued in request order.

Decomposition:
- Shared package imem_rsp_pkg:
  - PADDR_W=15, LINE_W=128, BEAT_W=32, ID_W=4
  - FSM state enum (IDLE, READ, WAIT_DATA, REQ, SEND, WAIT_ACK, RELEASE)
  - request entry struct {paddr[14:4], return id}
- Sub-module line_req_fifo: parameterised QDEPTH FIFO with push/pop/full/empty, async active-low reset.
- FSM, beat assembly and timeout stay in the top.

Test Plan:
1. Reset mid-WAIT_DATA -> all outputs 0, req_ready=1. Late mem_rd_data is not written to rsp_data; no rsp_req afterward.
2. Single read, paddr=15'h1234, return=0001, memory returns beats A0,A1,A2,A3:
   - mem_rd_addr 1230,1234,1238,123C in cycles 2-5
   - rsp_req from cycle 8; grant at 8 -> rsp_valid in cycle 9 with rsp_dest=0001, rsp_paddr=15'h1230, rsp_data={A3,A2,A1,A0}
   - ack at 10 -> rsp_release in cycle 11
3. Three back-to-back requests with QDEPTH=2 -> req_ready low once 2 entries are queued; three responses in order, no drops.
4. req_rw=1, paddr=15'h0040 -> err_rw pulses once, queue count unchanged, no mem_rd_en.
5. Grant delayed 5 cycles -> rsp_req held, payload unchanged. No ack for 16 cycles -> rsp_req reasserts and rsp_valid repeats with an identical payload.
6. Spurious rsp_grant/rsp_ack in IDLE and READ -> no state change, no rsp_valid.
